// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues one-outstanding fetches to
// instruction memory and drives the IF/ID pipeline register toward decode.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst_out,
  output logic [31:0] pc4_out,
  output logic        valid_out
);

  // state | meaning
  // FETCH | request driven at pc, waiting for grant
  // WAIT  | request granted, waiting for read data
  // HOLD  | fetched word parked because decode is stalled with a valid word
  // DROP  | redirect hit an in-flight read; swallow its data, pc is the target
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DROP  = 2'd3;

  logic [1:0]  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] hold_word, hold_nxt;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;
  logic        load;
  logic [31:0] load_word;
  logic [31:0] inst_nxt, pc4_nxt;
  logic        valid_nxt;
  logic        unused_redirect_bits;

  assign pc_plus4        = pc + 32'd4;
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_bits = ^redirect_pc[1:0];

  // Gated by rst_n so the request drops the instant reset asserts.
  assign imem_req  = (state == ST_FETCH) && rst_n;
  assign imem_addr = {pc[31:2], 2'b00};

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    hold_nxt  = hold_word;
    load      = 1'b0;
    load_word = imem_rdata;
    if (redirect_en) begin
      pc_nxt   = redirect_target;
      hold_nxt = NOP_WORD;
      case (state)
        ST_FETCH: state_nxt = imem_gnt    ? ST_DROP  : ST_FETCH;
        ST_WAIT:  state_nxt = imem_rvalid ? ST_FETCH : ST_DROP;
        ST_HOLD:  state_nxt = ST_FETCH;
        ST_DROP:  state_nxt = imem_rvalid ? ST_FETCH : ST_DROP;
        default:  state_nxt = ST_FETCH;
      endcase
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_gnt) state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (!id_stall || !valid_out) begin
              load      = 1'b1;
              load_word = imem_rdata;
              pc_nxt    = pc_plus4;
              state_nxt = ST_FETCH;
            end else begin
              hold_nxt  = imem_rdata;
              state_nxt = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!id_stall) begin
            load      = 1'b1;
            load_word = hold_word;
            pc_nxt    = pc_plus4;
            state_nxt = ST_FETCH;
          end
        end
        ST_DROP: begin
          if (imem_rvalid) state_nxt = ST_FETCH;
        end
        default: state_nxt = ST_FETCH;
      endcase
    end
  end

  // IF/ID register: flush beats load, load beats bubble, stall holds.
  always_comb begin
    inst_nxt  = inst_out;
    pc4_nxt   = pc4_out;
    valid_nxt = valid_out;
    if (redirect_en) begin
      inst_nxt  = NOP_WORD;
      valid_nxt = 1'b0;
    end else if (load) begin
      inst_nxt  = load_word;
      pc4_nxt   = pc_plus4;
      valid_nxt = 1'b1;
    end else if (!id_stall) begin
      inst_nxt  = NOP_WORD;
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FETCH;
      pc        <= RESET_PC;
      hold_word <= NOP_WORD;
      inst_out  <= NOP_WORD;
      pc4_out   <= 32'h0000_0000;
      valid_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      hold_word <= hold_nxt;
      inst_out  <= inst_nxt;
      pc4_out   <= pc4_nxt;
      valid_out <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: per-cycle vector table plus a hand-written
// reset-during-HOLD sequence.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] inst_out;
  logic [31:0] pc4_out;
  logic        valid_out;

  int errors = 0;
  int checks = 0;

  if_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_stall(id_stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .inst_out(inst_out), .pc4_out(pc4_out), .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic g, input logic rv, input logic [31:0] rd,
                              input logic st, input logic re, input logic [31:0] rp,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.gnt = g; v.rvalid = rv; v.rdata = rd; v.stall = st; v.redir = re; v.rpc = rp;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_inst = ei; v.e_pc4 = ep;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input int idx, input logic er, input logic [31:0] ea,
                            input logic ev, input logic [31:0] ei, input logic [31:0] ep);
    chk("imem_req", idx, {31'b0, imem_req}, {31'b0, er});
    chk("imem_addr", idx, imem_addr, ea);
    chk("valid_out", idx, {31'b0, valid_out}, {31'b0, ev});
    chk("inst_out", idx, inst_out, ei);
    chk("pc4_out", idx, pc4_out, ep);
  endtask

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                       input logic st, input logic re, input logic [31:0] rp);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    id_stall = st; redirect_en = re; redirect_pc = rp;
  endtask

  initial begin
    // Test 1: back-to-back fetches, 1-cycle memory, rdata = address
    add(1,0,32'h0,0,0,32'h0,           1,32'hBFC00000,0,32'h0,32'h0);
    add(0,1,32'hBFC00000,0,0,32'h0,    0,32'hBFC00000,0,32'h0,32'h0);
    add(1,0,32'h0,0,0,32'h0,           1,32'hBFC00004,1,32'hBFC00000,32'hBFC00004);
    add(0,1,32'hBFC00004,0,0,32'h0,    0,32'hBFC00004,0,32'h0,32'hBFC00004);
    add(1,0,32'h0,0,0,32'h0,           1,32'hBFC00008,1,32'hBFC00004,32'hBFC00008);
    add(0,1,32'hBFC00008,0,0,32'h0,    0,32'hBFC00008,0,32'h0,32'hBFC00008);
    add(0,0,32'h0,0,0,32'h0,           1,32'hBFC0000C,1,32'hBFC00008,32'hBFC0000C);
    // Test 2: stall with a valid word in IF/ID parks the next word in HOLD
    add(1,0,32'h0,0,0,32'h0,           1,32'hBFC0000C,0,32'h0,32'hBFC0000C);
    add(0,1,32'h11111111,0,0,32'h0,    0,32'hBFC0000C,0,32'h0,32'hBFC0000C);
    add(1,0,32'h0,1,0,32'h0,           1,32'hBFC00010,1,32'h11111111,32'hBFC00010);
    add(0,1,32'h24080005,1,0,32'h0,    0,32'hBFC00010,1,32'h11111111,32'hBFC00010);
    add(0,0,32'h0,1,0,32'h0,           0,32'hBFC00010,1,32'h11111111,32'hBFC00010);
    add(0,0,32'h0,1,0,32'h0,           0,32'hBFC00010,1,32'h11111111,32'hBFC00010);
    add(0,0,32'h0,1,0,32'h0,           0,32'hBFC00010,1,32'h11111111,32'hBFC00010);
    add(0,0,32'h0,0,0,32'h0,           0,32'hBFC00010,1,32'h11111111,32'hBFC00010);
    add(0,0,32'h0,0,0,32'h0,           1,32'hBFC00014,1,32'h24080005,32'hBFC00014);
    // Test 3: redirect in WAIT, rvalid 3 cycles later is discarded
    add(1,0,32'h0,0,0,32'h0,           1,32'hBFC00014,0,32'h0,32'hBFC00014);
    add(0,0,32'h0,0,1,32'h00400103,    0,32'hBFC00014,0,32'h0,32'hBFC00014);
    add(0,0,32'h0,0,0,32'h0,           0,32'h00400100,0,32'h0,32'hBFC00014);
    add(0,0,32'h0,0,0,32'h0,           0,32'h00400100,0,32'h0,32'hBFC00014);
    add(0,1,32'hDEADBEEF,0,0,32'h0,    0,32'h00400100,0,32'h0,32'hBFC00014);
    add(1,0,32'h0,0,0,32'h0,           1,32'h00400100,0,32'h0,32'hBFC00014);
    add(0,1,32'h3C010040,0,0,32'h0,    0,32'h00400100,0,32'h0,32'hBFC00014);
    // Test 4a: redirect coincident with rvalid in WAIT
    add(1,0,32'h0,0,0,32'h0,           1,32'h00400104,1,32'h3C010040,32'h00400104);
    add(0,1,32'hAAAAAAAA,0,1,32'h00001000, 0,32'h00400104,0,32'h0,32'h00400104);
    add(1,0,32'h0,0,0,32'h0,           1,32'h00001000,0,32'h0,32'h00400104);
    add(0,1,32'h20000001,0,0,32'h0,    0,32'h00001000,0,32'h0,32'h00400104);
    // Test 4b: redirect coincident with gnt in FETCH (flush overrides stall)
    add(1,0,32'h0,1,1,32'h00002000,    1,32'h00001004,1,32'h20000001,32'h00001004);
    add(0,0,32'h0,0,0,32'h0,           0,32'h00002000,0,32'h0,32'h00001004);
    add(0,1,32'hBBBBBBBB,0,0,32'h0,    0,32'h00002000,0,32'h0,32'h00001004);
    add(1,0,32'h0,0,0,32'h0,           1,32'h00002000,0,32'h0,32'h00001004);
    add(0,1,32'h20000002,0,0,32'h0,    0,32'h00002000,0,32'h0,32'h00001004);
    // Test 5: redirect to top of address space, pc+4 wraps
    add(0,0,32'h0,0,1,32'hFFFFFFFE,    1,32'h00002004,1,32'h20000002,32'h00002004);
    add(1,0,32'h0,0,0,32'h0,           1,32'hFFFFFFFC,0,32'h0,32'h00002004);
    add(0,1,32'h12345678,0,0,32'h0,    0,32'hFFFFFFFC,0,32'h0,32'h00002004);
    add(0,0,32'h0,0,0,32'h0,           1,32'h00000000,1,32'h12345678,32'h00000000);
    // stray rvalid in FETCH is ignored
    add(0,1,32'h55555555,0,0,32'h0,    1,32'h00000000,0,32'h0,32'h00000000);
    add(0,0,32'h0,0,0,32'h0,           1,32'h00000000,0,32'h0,32'h00000000);

    rst_n = 1'b0;
    drive(0,0,32'h0,0,0,32'h0);
    @(negedge clk);
    @(negedge clk);
    check_outs(-1, 1'b0, 32'hBFC00000, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].stall,
            vecs[i].redir, vecs[i].rpc);
      #1;
      check_outs(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                 vecs[i].e_inst, vecs[i].e_pc4);
      @(negedge clk);
    end

    // Test 6: async reset while parked in HOLD with a valid word
    drive(1,0,32'h0,0,0,32'h0);            @(negedge clk);
    drive(0,1,32'hCAFE0001,0,0,32'h0);     @(negedge clk);
    drive(1,0,32'h0,1,0,32'h0);            @(negedge clk);
    drive(0,1,32'hCAFE0002,1,0,32'h0);     @(negedge clk);
    drive(0,0,32'h0,1,0,32'h0);
    #1;
    check_outs(100, 1'b0, 32'h00000004, 1'b1, 32'hCAFE0001, 32'h00000004);
    #1;
    rst_n = 1'b0;
    #1;
    check_outs(101, 1'b0, 32'hBFC00000, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    drive(0,0,32'h0,0,0,32'h0);
    rst_n = 1'b1;
    #1;
    check_outs(102, 1'b1, 32'hBFC00000, 1'b0, 32'h0, 32'h0);
    drive(1,0,32'h0,0,0,32'h0);            @(negedge clk);
    drive(0,1,32'h3C1DBFC0,0,0,32'h0);     @(negedge clk);
    drive(0,0,32'h0,0,0,32'h0);
    #1;
    check_outs(103, 1'b1, 32'hBFC00004, 1'b1, 32'h3C1DBFC0, 32'hBFC00004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction fetch stage of the 5-stage MIPS R2000 pipeline; producer side of the IF/ID interface that feeds the decode stage's 32-bit instruction input.
- Owns the PC and issues one-outstanding requests to instruction memory.
- Holds fetched words in the IF/ID pipeline register.
- Honours decode stalls and branch/jump redirects from downstream stages.

Parameters:
RESET_PC, 32'hBFC0_0000, PC value loaded on reset (MIPS reset vector)
NOP_WORD, 32'h0000_0000, instruction word driven on inst_out when the register holds no valid instruction (sll $0,$0,0)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  word-aligned fetch address
imem_gnt  in  1  memory accepted request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  instruction word
id_stall  in  1  decode cannot accept; IF/ID register must hold
redirect_en  in  1  branch/jump taken; flush and refetch
redirect_pc  in  32  target address; bits [1:0] ignored
inst_out  out  32  IF/ID instruction to decode
pc4_out  out  32  PC+4 of inst_out (for link/branch arithmetic)
valid_out  out  1  inst_out holds a real instruction

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC, state=FETCH.
  - imem_req=0, imem_addr=RESET_PC.
  - inst_out=NOP_WORD, pc4_out=0, valid_out=0.
  - hold buffer empty.
  - Reset mid-transaction abandons any outstanding read. Memory must not return rvalid for a pre-reset request after rst_n rises; that is the memory's responsibility.
- imem_addr = {pc[31:2],2'b00} at all times.
- imem_req=1 only in FETCH.
- At most one outstanding request.
- States:
  - FETCH: imem_req=1. imem_gnt=1 -> WAIT; otherwise stay.
  - WAIT: imem_req=0. On imem_rvalid:
    - if IF/ID can load (id_stall=0 or valid_out=0): inst_out<=imem_rdata, pc4_out<=pc+4, valid_out<=1, pc<=pc+4, -> FETCH.
    - else: hold<=imem_rdata, -> HOLD.
  - HOLD: imem_req=0. When id_stall=0: inst_out<=hold, pc4_out<=pc+4, valid_out<=1, pc<=pc+4, -> FETCH.
  - DROP: imem_req=0. Wait for imem_rvalid, discard the data, -> FETCH. pc is unchanged (already holds the target).
- IF/ID consumption:
  - With id_stall=0 and no new word arriving this cycle, valid_out<=0 and inst_out<=NOP_WORD (bubble).
  - With id_stall=1, inst_out, pc4_out and valid_out hold.
- Redirect (redirect_en=1) has priority over everything except reset:
  - pc<={redirect_pc[31:2],2'b00}.
  - valid_out<=0, inst_out<=NOP_WORD. Flush overrides id_stall.
  - hold discarded.
  - Next state:
    - FETCH without gnt -> FETCH (the next request uses the new pc).
    - FETCH with gnt the same cycle -> DROP.
    - WAIT without rvalid -> DROP.
    - WAIT with rvalid the same cycle -> data discarded, -> FETCH.
    - HOLD -> FETCH.
    - DROP without rvalid -> stays DROP.
    - DROP with rvalid -> FETCH.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); no exception is raised.
- Throughput and latency:
  - Best case is one instruction per 2 cycles: gnt in cycle N, rvalid in N+1, valid_out visible in N+2.
  - Memory latency is arbitrary (≥1 cycle after gnt).
- imem_rvalid outside WAIT/DROP is a protocol error; it is ignored.

Test Plan:
1. Reset release, memory with 1-cycle latency, id_stall=0, rdata=address -> imem_addr sequence BFC00000, BFC00004, BFC00008. inst_out equals those words with pc4_out = address+4. valid_out pulses every 2nd cycle.
2. id_stall=1 held 5 cycles while word 0x2408_0005 arrives with valid_out=1 already set -> word parked in HOLD, imem_req=0, outputs frozen. One cycle after the stall drops, inst_out=0x2408_0005 and the next fetch is issued.
3. redirect_en=1 with redirect_pc=0x0040_0103 while in WAIT, rvalid 3 cycles later -> returned word discarded, valid_out=0, next imem_addr=0x0040_0100.
4. redirect_en coincident with imem_rvalid in WAIT, and separately coincident with imem_gnt in FETCH -> first case: data dropped, immediate FETCH of the target. Second case: DROP state, one rvalid swallowed, then the target is fetched.
5. pc forced via redirect to 0xFFFF_FFFC, word fetched -> next imem_addr=0x0000_0000, pc4_out=0x0000_0000.
6. rst_n asserted low while in HOLD with valid_out=1 -> outputs immediately take reset values (valid_out=0, inst_out=NOP_WORD). After release, the first imem_addr is 0xBFC0_0000.
